stopwatch_ctrl: RTL
===================

# stopwatch_ctrl

Control unit that sequences the stopwatch counter datapath. It synchronises and edge-detects the raw push-buttons and divides the system clock into a count tick. It runs a run/lap/stop/step state machine and emits count-enable, clear and display-hold strobes to the BCD counter and display blocks. It sits between the board buttons and the counter chain, replacing ad-hoc enable logic.

## Interface
- TICK_DIV, 100000: system clocks per count tick, ≥2; tick is 1 ms at 100 MHz.
- REPEAT_DLY, 500: ticks inc must be held in STEP before auto-repeat starts, ≥1.
- REPEAT_RATE, 50: ticks between auto-repeat pulses, ≥1.
- clk  in  1  system clock, all logic on rising edge.
- rst  in  1  reset; one clock; reset is asynchronous and active-low.
- start_btn  in  1  raw start button, asynchronous to clk.
- stop_btn  in  1  raw stop button.
- inc_btn  in  1  raw manual-increment button.
- lap_btn  in  1  raw lap button.
- clr_btn  in  1  raw clear button.
- cnt_en  out  1  one-cycle count strobe to the counter chain.
- cnt_clr  out  1  one-cycle synchronous clear strobe to the counter chain.
- disp_hold  out  1  freeze display latch while high.
- running  out  1  high in RUN or LAP.
- state  out  2  current state encoding, for debug and LEDs.

## Operation
- Each button goes through a 2-flop synchroniser, then a rising-edge detector, giving a pulse one cycle wide per press. The level of sync stage 2 is `inc_s`.
- Prescaler: a counter from 0 to TICK_DIV-1. `tick` is high for one cycle when the prescaler is at TICK_DIV-1, after which it wraps to 0. The prescaler runs only in RUN, LAP and STEP. It is held at 0 in STOP and is cleared on every state entry.
- States: STOP=00, RUN=01, LAP=10, STEP=11. Reset state is STOP.
- Edge-pulse priority within one cycle: clr > stop > start > lap > inc. Only the highest-priority applicable pulse acts; the others are dropped.
- Transitions from STOP:
  - start → RUN.
  - inc → STEP.
  - clr → cnt_clr for 1 cycle; stay in STOP.
- Transitions from RUN:
  - stop → STOP.
  - lap → LAP.
  - clr and inc are ignored.
- Transitions from LAP:
  - lap → RUN.
  - stop → STOP.
  - clr and inc are ignored.
- Transitions from STEP:
  - stop → STOP.
  - `inc_s` low → STOP.
  - start, lap and clr are ignored.
- cnt_en in RUN and LAP equals `tick`. The counter keeps running during LAP.
- cnt_en in STEP:
  - High for exactly the first cycle in STEP.
  - Auto-repeat (macro dependent): pulses coincide with `tick` once REPEAT_DLY ticks have elapsed in STEP, then every REPEAT_RATE ticks.
  - The hold-tick counter is 16 bits and saturates. It is cleared on STEP entry.
- disp_hold is high only in LAP.
- running is high in RUN and LAP.
- cnt_en and cnt_clr are never high in the same cycle.

## Timing
- Reset values: state=STOP, cnt_en=0, cnt_clr=0, disp_hold=0, running=0, prescaler=0, hold counter=0, synchronisers=0.
- Button latency: input first sampled high at edge N → state and outputs change after edge N+2.
- A held button produces a single edge pulse. Re-arming requires the synchronised level to go low for at least 1 cycle.
- Entry into RUN: first cnt_en comes TICK_DIV cycles after the state change.
- Stop at the same edge as a tick: the state moves to STOP and that tick's cnt_en is still issued, because cnt_en decodes the current state.
- Reset asserted mid-operation: all registers clear immediately. The first press after deassertion needs the full 3-edge latency.
- Outputs are decoded from registered state and prescaler only, with no combinational path from button pins.

## Configuration
- `STOPWATCH_AUTOREPEAT_EN` defined: STEP issues the entry pulse plus auto-repeat pulses while inc is held, as described above.
- Macro undefined:
  - STEP issues only the single entry pulse.
  - The hold-tick counter and the REPEAT_* logic are not built; the parameters remain but are unused.
  - STEP still exits on `inc_s` low or stop.

## Test plan
All scenarios use TICK_DIV=4, REPEAT_DLY=3, REPEAT_RATE=2.
- Reset, then start pressed for 5 cycles → state=RUN on the 3rd edge; cnt_en pulses every 4 cycles, first pulse 4 cycles after entry; 10 pulses in 40 cycles.
- RUN, lap press → LAP with disp_hold=1 while cnt_en continues every 4 cycles; second lap press → RUN with disp_hold=0; stop press → STOP, cnt_en stops, running=0.
- STOP, clr press → cnt_clr high for exactly 1 cycle, state stays STOP. The same clr press in RUN → no cnt_clr.
- STOP, inc held for 30 cycles:
  - With the macro: cnt_en at the first STEP cycle, then at ticks 3, 5, 7, … (cycles 12, 20, 28 after entry).
  - Without the macro: a single pulse.
  - In both cases, release returns the state to STOP.
- Start and stop pressed on the same cycle in STOP → stop wins, state stays STOP. clr and start together → cnt_clr, state stays STOP.
- Reset driven low mid-RUN for 1 cycle → all outputs 0 and state=STOP asynchronously; no cnt_en afterwards until a new start.

Source files
------------

// File: rtl/stopwatch_ctrl.sv
// Stopwatch control unit: button synchronisers, count-tick prescaler and the
// STOP/RUN/LAP/STEP sequencer. STOPWATCH_AUTOREPEAT_EN enables STEP auto-repeat.
module stopwatch_ctrl #(
    parameter int TICK_DIV    = 100000,
    parameter int REPEAT_DLY  = 500,
    parameter int REPEAT_RATE = 50
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start_btn,
    input  logic       stop_btn,
    input  logic       inc_btn,
    input  logic       lap_btn,
    input  logic       clr_btn,
    output logic       cnt_en,
    output logic       cnt_clr,
    output logic       disp_hold,
    output logic       running,
    output logic [1:0] state
);

    typedef enum logic [1:0] {
        ST_STOP = 2'b00,
        ST_RUN  = 2'b01,
        ST_LAP  = 2'b10,
        ST_STEP = 2'b11
    } state_t;

    localparam int             PW      = $clog2(TICK_DIV);
    localparam logic [PW-1:0]  PRE_MAX = PW'(TICK_DIV - 1);

    if (TICK_DIV < 2 || REPEAT_DLY < 1 || REPEAT_RATE < 1) begin : g_param_check
        $error("stopwatch_ctrl: TICK_DIV must be >= 2, REPEAT_DLY and REPEAT_RATE >= 1");
    end

    // Button bits: 0 start, 1 stop, 2 lap, 3 inc, 4 clr. Stage 3 only feeds the edge detector.
    logic [4:0] btn_raw;
    logic [4:0] sync1, sync2, sync3;
    logic [4:0] edge_p;
    logic       start_p, stop_p, lap_p, inc_p, clr_p, inc_s;

    assign btn_raw = {clr_btn, inc_btn, lap_btn, stop_btn, start_btn};

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync1 <= '0;
            sync2 <= '0;
            sync3 <= '0;
        end else begin
            sync1 <= btn_raw;
            sync2 <= sync1;
            sync3 <= sync2;
        end
    end

    assign edge_p  = sync2 & ~sync3;
    assign start_p = edge_p[0];
    assign stop_p  = edge_p[1];
    assign lap_p   = edge_p[2];
    assign inc_p   = edge_p[3];
    assign clr_p   = edge_p[4];
    assign inc_s   = sync2[3];

    state_t        cur, nxt;
    logic          clr_req;
    logic [PW-1:0] presc;
    logic          tick;
    logic          step_first;
    logic          rep_fire;

    // Each state only looks at the pulses that mean something to it, highest priority first.
    always_comb begin
        nxt     = cur;
        clr_req = 1'b0;
        case (cur)
            ST_STOP: begin
                if (clr_p)
                    clr_req = 1'b1;
                else if (!stop_p) begin
                    if (start_p)
                        nxt = ST_RUN;
                    else if (inc_p)
                        nxt = ST_STEP;
                end
            end
            ST_RUN: begin
                if (stop_p)
                    nxt = ST_STOP;
                else if (lap_p)
                    nxt = ST_LAP;
            end
            ST_LAP: begin
                if (stop_p)
                    nxt = ST_STOP;
                else if (lap_p)
                    nxt = ST_RUN;
            end
            ST_STEP: begin
                if (stop_p || !inc_s)
                    nxt = ST_STOP;
            end
            default: nxt = ST_STOP;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cur        <= ST_STOP;
            cnt_clr    <= 1'b0;
            step_first <= 1'b0;
        end else begin
            cur        <= nxt;
            cnt_clr    <= clr_req;
            step_first <= (nxt == ST_STEP) && (cur != ST_STEP);
        end
    end

    // Prescaler restarts on every state change so the first tick is a full period away.
    assign tick = (cur != ST_STOP) && (presc == PRE_MAX);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            presc <= '0;
        else if ((nxt != cur) || (cur == ST_STOP) || tick)
            presc <= '0;
        else
            presc <= presc + 1'b1;
    end

`ifdef STOPWATCH_AUTOREPEAT_EN
    localparam logic [15:0] DLY_M1  = 16'(REPEAT_DLY - 1);
    localparam logic [15:0] RATE_M1 = 16'(REPEAT_RATE - 1);

    // hold_cnt counts ticks already seen in STEP; rate_cnt spaces repeats after the first.
    logic [15:0] hold_cnt, rate_cnt;

    assign rep_fire = (cur == ST_STEP) && tick &&
                      ((hold_cnt == DLY_M1) || ((hold_cnt > DLY_M1) && (rate_cnt == RATE_M1)));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            hold_cnt <= '0;
            rate_cnt <= '0;
        end else if (cur != ST_STEP) begin
            hold_cnt <= '0;
            rate_cnt <= '0;
        end else if (tick) begin
            if (hold_cnt != 16'hFFFF)
                hold_cnt <= hold_cnt + 16'd1;
            if (rep_fire)
                rate_cnt <= '0;
            else if (hold_cnt > DLY_M1)
                rate_cnt <= rate_cnt + 16'd1;
        end
    end
`else
    assign rep_fire = 1'b0;
`endif

    assign cnt_en    = (((cur == ST_RUN) || (cur == ST_LAP)) && tick) ||
                       ((cur == ST_STEP) && (step_first || rep_fire));
    assign disp_hold = (cur == ST_LAP);
    assign running   = (cur == ST_RUN) || (cur == ST_LAP);
    assign state     = cur;

endmodule
